// File: rtl/line_f.sv
// Instruction fetch stage: owns the PC, issues one read at a time to a
// variable-latency instruction memory, buffers returned words in a 2-entry
// queue feeding decode, and applies branch-delay-slot redirects.
module line_f #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic        npc_on,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_out,
  output logic [31:0] pc_out,
  output logic        f_valid
);

  // Memory handshake: a request transfers on a rising edge where
  // imem_req && imem_ready; imem_req never waits on imem_ready. Exactly one
  // transfer may be in flight, and its data returns with imem_rvalid at least
  // one cycle after the transfer. imem_rvalid seen with nothing in flight is
  // ignored, so a response that straddles a reset is harmless.

  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        outstanding;
  logic        drop;
  logic [1:0]  count;
  logic [31:0] q_pc  [2];
  logic [31:0] q_ins [2];
  logic [31:0] last_pc;
  logic        rd_pend;
  logic [31:0] rd_target;
  logic [31:0] rd_slot;

  logic        consume;
  logic        resp;
  logic        push;
  logic        redir_a;
  logic        redir_b;
  logic        redir_res;
  logic        flush;
  logic [31:0] flush_pc;
  logic [1:0]  count_nxt;
  logic        out_free;
  logic        accept;
  logic        in_flight_after;

  assign consume   = !stop && (count != 2'd0);
  assign resp      = imem_rvalid && outstanding;
  // Redirect seen while the queue holds the delay slot.
  assign redir_a   = npc_on && !stop && (count != 2'd0) && !rd_pend;
  // Redirect seen with the queue empty: remember it until the slot leaves.
  assign redir_b   = npc_on && !stop && (count == 2'd0) && !rd_pend;
  assign redir_res = rd_pend && consume && (q_pc[0] == rd_slot);
  assign flush     = redir_a || redir_res;
  assign flush_pc  = redir_res ? rd_target : pc_next;
  // A word arriving on a flushing edge is always past the delay slot.
  assign push      = resp && !drop && !flush;

  // Queue occupancy after this edge; drives the request decision.
  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = 2'd0;
    else if (push && !consume)
      count_nxt = count + 2'd1;
    else if (!push && consume)
      count_nxt = count - 2'd1;
  end

  assign out_free        = !outstanding || resp;
  assign imem_req        = reset && out_free && (count_nxt != 2'd2);
  assign imem_addr       = fetch_pc;
  assign accept          = imem_req && imem_ready;
  assign in_flight_after = (outstanding && !resp) || accept;

  assign f_valid = (count != 2'd0);
  assign ins_out = f_valid ? q_ins[0] : 32'h0;
  assign pc_out  = f_valid ? q_pc[0]  : 32'h0;

  // Fetch PC, request tracking, wrong-path drop flag and delivered-PC record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      count       <= 2'd0;
      last_pc     <= RESET_PC - 32'd4;
    end else begin
      count       <= count_nxt;
      outstanding <= in_flight_after;
      if (accept)
        req_pc <= fetch_pc;
      if (flush)
        fetch_pc <= flush_pc;
      else if (accept)
        fetch_pc <= fetch_pc + 32'd4;
      // Anything still in flight after a flush is on the wrong path.
      if (flush)
        drop <= in_flight_after;
      else if (resp)
        drop <= 1'b0;
      if (consume)
        last_pc <= q_pc[0];
    end
  end

  // Two-entry queue with the head always in slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_pc[0]  <= 32'h0;
      q_pc[1]  <= 32'h0;
      q_ins[0] <= 32'h0;
      q_ins[1] <= 32'h0;
    end else if (!flush) begin
      case ({push, consume})
        2'b10: begin
          if (count == 2'd0) begin
            q_pc[0]  <= req_pc;
            q_ins[0] <= imem_rdata;
          end else begin
            q_pc[1]  <= req_pc;
            q_ins[1] <= imem_rdata;
          end
        end
        2'b01: begin
          q_pc[0]  <= q_pc[1];
          q_ins[0] <= q_ins[1];
        end
        2'b11: begin
          if (count == 2'd1) begin
            q_pc[0]  <= req_pc;
            q_ins[0] <= imem_rdata;
          end else begin
            q_pc[0]  <= q_pc[1];
            q_ins[0] <= q_ins[1];
            q_pc[1]  <= req_pc;
            q_ins[1] <= imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Deferred redirect: target and delay-slot PC held until the slot is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend   <= 1'b0;
      rd_target <= 32'h0;
      rd_slot   <= 32'h0;
    end else if (redir_res) begin
      rd_pend <= 1'b0;
    end else if (redir_b) begin
      rd_pend   <= 1'b1;
      rd_target <= pc_next;
      rd_slot   <= last_pc + 32'd4;
    end
  end

endmodule
